// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, RELEASE)
//   DEF_NUM_CH / DEF_MAX_BURST : default channel count and burst bound
//   ch_idx_t    : channel index type for the default channel count
package arb_pkg;

  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_MAX_BURST = 256;

  typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: finds the first set bit of cand scanning upward from ptr,
// wrapping from NUM_CH-1 back to 0.
//   cand  : candidate request vector, bit i = channel i
//   ptr   : starting channel for the scan (must be < NUM_CH)
//   idx   : chosen channel index (0 when nothing found)
//   found : cand has at least one bit set
module rr_pick #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] cand,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  // ptr + k modulo NUM_CH; explicit subtract so non-power-of-2 counts wrap.
  function automatic logic [CH_W-1:0] add_wrap(input logic [CH_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Scan from the far end down so the closest hit to ptr is assigned last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand[add_wrap(ptr, k)]) begin
        found = 1'b1;
        idx   = add_wrap(ptr, k);
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter selecting which peripheral RX FIFO drains into
// the FT601 upstream path. Channels that are almost full form an urgent class
// served ahead of ordinary requesters; each grant is bounded to MAX_BURST
// words and is followed by a one-cycle turnaround before the next grant.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   rx_fifo_empty        : per-channel FIFO empty (request = ~empty)
//   rx_fifo_almost_full  : per-channel almost-full (urgent only if not empty)
//   tx_ready             : FT601 side can accept a burst
//   word_taken           : one word popped from the granted channel this cycle
//   grant_valid          : grant active
//   grant_ch             : granted channel (held through release/idle)
//   grant_urgent         : current grant won in the urgent class
//   burst_cnt            : words taken during the current grant
//
// Build option: define URGENT_PREEMPT_EN to let an urgent request on another
// channel cut short a non-urgent burst.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  rx_fifo_empty,
  input  logic [NUM_CH-1:0]  rx_fifo_almost_full,
  input  logic               tx_ready,
  input  logic               word_taken,
  output logic               grant_valid,
  output logic [CH_W-1:0]    grant_ch,
  output logic               grant_urgent,
  output logic [BURST_W-1:0] burst_cnt
);

  localparam logic [BURST_W-1:0] CNT_MAX   = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] CNT_LAST  = BURST_W'(MAX_BURST - 1);
  localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(NUM_CH - 1);

  arb_state_e         state_q, state_d;
  logic [CH_W-1:0]    grant_ch_q, grant_ch_d;
  logic               urgent_q, urgent_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;

  logic [NUM_CH-1:0]  req, urg, cand;
  logic [CH_W-1:0]    pick_idx;
  logic               pick_found;
  logic               release_now;
  logic               preempt;

  assign req  = ~rx_fifo_empty;
  assign urg  = rx_fifo_almost_full & req;
  assign cand = (|urg) ? urg : req;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef URGENT_PREEMPT_EN
  logic [NUM_CH-1:0] ch_oh;
  assign ch_oh   = NUM_CH'(1) << grant_ch_q;
  assign preempt = !urgent_q && |(urg & ~ch_oh);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_ch_d  = grant_ch_q;
    urgent_d    = urgent_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && pick_found) begin
          state_d    = GRANT;
          grant_ch_d = pick_idx;
          urgent_d   = |urg;
          cnt_d      = '0;
        end
      end
      GRANT: begin
        if (word_taken && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        // Any combination of these ends the burst exactly once.
        release_now = (word_taken && (cnt_q == CNT_LAST))
                    || (rx_fifo_empty[grant_ch_q] && !word_taken)
                    || !tx_ready
                    || preempt;
        if (release_now) begin
          state_d = RELEASE;
          ptr_d   = (grant_ch_q == LAST_CH) ? '0 : grant_ch_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;  // FT601 turnaround
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_ch_q <= '0;
      urgent_q   <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      urgent_q   <= urgent_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_ch     = grant_ch_q;
  assign grant_urgent = urgent_q;
  assign burst_cnt    = cnt_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: an 8-channel and a 5-channel instance (both
// MAX_BURST=4) checked every cycle against a behavioural model, plus directed
// sequences with hand-computed expectations. Honours URGENT_PREEMPT_EN.
module tb_rr_burst_arbiter;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] emp8, af8;
  logic       tx8, wt8;
  logic       gv8, gu8;
  logic [2:0] gc8, bc8;

  logic [4:0] emp5, af5;
  logic       tx5, wt5;
  logic       gv5, gu5;
  logic [2:0] gc5, bc5;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rr_burst_arbiter #(.NUM_CH(8), .MAX_BURST(MB)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .rx_fifo_empty(emp8), .rx_fifo_almost_full(af8),
    .tx_ready(tx8), .word_taken(wt8),
    .grant_valid(gv8), .grant_ch(gc8), .grant_urgent(gu8), .burst_cnt(bc8)
  );

  rr_burst_arbiter #(.NUM_CH(5), .MAX_BURST(MB)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .rx_fifo_empty(emp5), .rx_fifo_almost_full(af5),
    .tx_ready(tx5), .word_taken(wt5),
    .grant_valid(gv5), .grant_ch(gc5), .grant_urgent(gu5), .burst_cnt(bc5)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit valid;
    bit gap;
    int ch;
    bit urgent;
    int cnt;
    int ptr;
  } mdl_t;

  mdl_t m8, m5;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.valid = 0; r.gap = 0; r.ch = 0; r.urgent = 0; r.cnt = 0; r.ptr = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, logic [7:0] emp, logic [7:0] af,
                                    logic txr, logic wt);
    mdl_t r = m;
    bit [7:0] req, urg, pool;
    bit preempt = 0;
    for (int i = 0; i < 8; i++) begin
      req[i] = (i < n) && !emp[i];
      urg[i] = req[i] && af[i];
    end
    if (m.gap) begin
      r.gap = 0;
    end else if (!m.valid) begin
      pool = (urg != 0) ? urg : req;
      if (txr && pool != 0) begin
        for (int k = n - 1; k >= 0; k--)
          if (pool[(m.ptr + k) % n]) r.ch = (m.ptr + k) % n;
        r.valid  = 1;
        r.urgent = (urg != 0);
        r.cnt    = 0;
      end
    end else begin
      if (wt && m.cnt < MB) r.cnt = m.cnt + 1;
`ifdef URGENT_PREEMPT_EN
      for (int j = 0; j < n; j++)
        if (urg[j] && j != m.ch && !m.urgent) preempt = 1;
`endif
      if ((wt && r.cnt == MB) || (emp[m.ch] && !wt) || !txr || preempt) begin
        r.valid = 0;
        r.gap   = 1;
        r.ptr   = (m.ch + 1) % n;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= mdl_reset();
      m5 <= mdl_reset();
    end else begin
      m8 <= mdl_step(m8, 8, emp8, af8, tx8, wt8);
      m5 <= mdl_step(m5, 5, {3'b111, emp5}, {3'b000, af5}, tx5, wt5);
    end
  end

  task automatic cmp(input string nm, input logic gv, input logic [2:0] gc, input logic gu,
                     input logic [2:0] bc, input mdl_t m);
    nvec++;
    if (gv !== m.valid || gu !== m.urgent || $isunknown(gc) || $isunknown(bc) ||
        int'(gc) != m.ch || int'(bc) != m.cnt) begin
      nerr++;
      $display("FAIL %s vs model t=%0t: got v=%0b ch=%0d u=%0b cnt=%0d, want v=%0b ch=%0d u=%0b cnt=%0d",
               nm, $time, gv, gc, gu, bc, m.valid, m.ch, m.urgent, m.cnt);
    end
  endtask

  // Single compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cmp("dut8", gv8, gc8, gu8, bc8, m8);
      cmp("dut5", gv5, gc5, gu5, bc5, m5);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until grant_valid of the selected instance equals want.
  task automatic wait_v(input bit sel5, input logic want, output int n);
    n = 0;
    while (((sel5 ? gv5 : gv8) !== want) && n < 40) begin
      tick();
      n++;
    end
    if ((sel5 ? gv5 : gv8) !== want) begin
      nvec++;
      nerr++;
      $display("FAIL timeout waiting grant_valid=%0b on dut%0d", want, sel5 ? 5 : 8);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    emp8 = '1; af8 = '0; tx8 = 1'b0; wt8 = 1'b0;
    emp5 = '1; af5 = '0; tx5 = 1'b0; wt5 = 1'b0;
    tick();
    tick();
    chk("rst_valid", int'(gv8), 0);
    chk("rst_ch", int'(gc8), 0);
    chk("rst_urgent", int'(gu8), 0);
    chk("rst_cnt", int'(bc8), 0);
    chk("rst_valid5", int'(gv5), 0);
    rst_n = 1'b1;

    // 1: ch0 and ch2 request; ch0 empties after 3 words.
    emp8 = ~8'b0000_0101; tx8 = 1'b1; wt8 = 1'b1;
    wait_v(0, 1'b1, n);
    chk("t1_latency", n, 1);
    chk("t1_ch", int'(gc8), 0);
    n = 0;
    while (bc8 !== 3'd3 && n < 10) begin tick(); n++; end
    emp8[0] = 1'b1; wt8 = 1'b0;
    tick();
    chk("t1_rel_valid", int'(gv8), 0);
    chk("t1_rel_ch", int'(gc8), 0);
    chk("t1_rel_cnt", int'(bc8), 3);
    wt8 = 1'b1;
    wait_v(0, 1'b1, n);
    chk("t1_gap", n, 2);
    chk("t1_ch2", int'(gc8), 2);
    chk("t1_ch2_urg", int'(gu8), 0);
    wait_v(0, 1'b0, n);
    chk("t1_ch2_len", n, 4);
    chk("t1_ch2_cnt", int'(bc8), 4);

    // 2: all channels busy, bursts of MAX_BURST in order 0..7,0.
    do_reset();
    emp8 = '0; af8 = '0; tx8 = 1'b1; wt8 = 1'b1;
    wait_v(0, 1'b1, n);
    chk("t2_latency", n, 1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2_ch[%0d]", i), int'(gc8), i % 8);
      wait_v(0, 1'b0, n);
      chk($sformatf("t2_len[%0d]", i), n, 4);
      chk($sformatf("t2_cnt[%0d]", i), int'(bc8), 4);
      if (i < 8) begin
        wait_v(0, 1'b1, n);
        chk($sformatf("t2_gap[%0d]", i), n, 2);
      end
    end

    // 3: urgent class wins over the pointer.
    do_reset();
    emp8 = '0; af8 = 8'b0010_0000; tx8 = 1'b1; wt8 = 1'b0;
    wait_v(0, 1'b1, n);
    chk("t3_ch", int'(gc8), 5);
    chk("t3_urg", int'(gu8), 1);
    tick(); tick(); tick();
    chk("t3_hold", int'(gv8), 1);
    tx8 = 1'b0;
    tick();
    chk("t3_rel", int'(gv8), 0);

    // 4: tx_ready drops mid-burst on ch1.
    do_reset();
    emp8 = ~8'b0000_0010; af8 = '0; tx8 = 1'b1; wt8 = 1'b0;
    wait_v(0, 1'b1, n);
    chk("t4_ch", int'(gc8), 1);
    wt8 = 1'b1;
    tick(); tick();
    wt8 = 1'b0; tx8 = 1'b0;
    tick();
    chk("t4_rel_valid", int'(gv8), 0);
    chk("t4_rel_cnt", int'(bc8), 2);
    repeat (6) tick();
    chk("t4_no_grant", int'(gv8), 0);
    tx8 = 1'b1;
    wait_v(0, 1'b1, n);
    chk("t4_regrant_lat", n, 1);
    chk("t4_regrant_ch", int'(gc8), 1);

    // 5: urgent request arrives during a non-urgent burst.
    do_reset();
    emp8 = ~8'b0000_1001; af8 = '0; tx8 = 1'b1; wt8 = 1'b0;
    wait_v(0, 1'b1, n);
    chk("t5_ch0", int'(gc8), 0);
    chk("t5_ch0_urg", int'(gu8), 0);
    wt8 = 1'b1;
    tick();
    af8 = 8'b0000_1000;
    tick();
`ifdef URGENT_PREEMPT_EN
    chk("t5_preempt_valid", int'(gv8), 0);
    chk("t5_preempt_cnt", int'(bc8), 2);
`else
    chk("t5_cont_valid", int'(gv8), 1);
    wait_v(0, 1'b0, n);
    chk("t5_full_cnt", int'(bc8), 4);
`endif
    wait_v(0, 1'b1, n);
    chk("t5_ch3", int'(gc8), 3);
    chk("t5_ch3_urg", int'(gu8), 1);
    tx8 = 1'b0; wt8 = 1'b0;
    tick();

    // 6: five channels, pointer wraps 4 -> 0; async reset mid-grant.
    do_reset();
    emp8 = '1; af8 = '0;
    emp5 = '0; af5 = '0; tx5 = 1'b1; wt5 = 1'b1;
    wait_v(1, 1'b1, n);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_ch[%0d]", i), int'(gc5), i % 5);
      wait_v(1, 1'b0, n);
      chk($sformatf("t6_cnt[%0d]", i), int'(bc5), 4);
      wait_v(1, 1'b1, n);
    end
    chk("t6_ch_after_wrap", int'(gc5), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(gv5), 0);
    chk("t6_async_ch", int'(gc5), 0);
    chk("t6_async_cnt", int'(bc5), 0);
    rst_n = 1'b1;
    wait_v(1, 1'b1, n);
    chk("t6_post_rst_lat", n, 1);
    chk("t6_post_rst_ch", int'(gc5), 0);
    tx5 = 1'b0; wt5 = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
